// File: rtl/dht11_sensor_emulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dht11_sensor_emulator_if                                          |
// | Brief  : Line, payload and status signals of the DHT11 sensor emulator.    |
// |          master = host/board side, slave = emulator.                       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
interface dht11_sensor_emulator_if;
  logic       enable;
  logic       dht_in;
  logic       dht_oe;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic [7:0] chk_xor;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable, dht_in, hum_int, hum_dec, temp_int, temp_dec, chk_xor,
    input  dht_oe, busy, frame_done
  );

  modport slave (
    input  enable, dht_in, hum_int, hum_dec, temp_int, temp_dec, chk_xor,
    output dht_oe, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/dht11_sensor_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dht11_sensor_emulator                                             |
// | Brief  : Sensor end of the DHT11 single-wire protocol. Detects a host      |
// |          start pulse and replies with preamble + 40-bit MSB-first frame.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module dht11_sensor_emulator #(
  parameter int CYC_PER_US   = 50,
  parameter int START_MIN_US = 18000,
  parameter int WAIT_US      = 30,
  parameter int RESP_LOW_US  = 80,
  parameter int RESP_HIGH_US = 80,
  parameter int BIT_LOW_US   = 50,
  parameter int ZERO_HIGH_US = 26,
  parameter int ONE_HIGH_US  = 70,
  parameter int END_LOW_US   = 50
) (
  input  wire logic               clk_50Mhz,
  input  wire logic               rst_n,
  dht11_sensor_emulator_if.slave  bus
);

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int C_START_CYC = START_MIN_US * CYC_PER_US;
  localparam int C_WAIT_CYC  = WAIT_US      * CYC_PER_US;
  localparam int C_RLOW_CYC  = RESP_LOW_US  * CYC_PER_US;
  localparam int C_RHIGH_CYC = RESP_HIGH_US * CYC_PER_US;
  localparam int C_BLOW_CYC  = BIT_LOW_US   * CYC_PER_US;
  localparam int C_ZERO_CYC  = ZERO_HIGH_US * CYC_PER_US;
  localparam int C_ONE_CYC   = ONE_HIGH_US  * CYC_PER_US;
  localparam int C_END_CYC   = END_LOW_US   * CYC_PER_US;
  localparam int C_PH_MAX    = f_max(f_max(f_max(C_WAIT_CYC, C_RLOW_CYC), f_max(C_RHIGH_CYC, C_BLOW_CYC)),
                                     f_max(f_max(C_ZERO_CYC, C_ONE_CYC), C_END_CYC));
  localparam int C_PH_W      = $clog2(C_PH_MAX + 1);
  localparam int C_LOW_W     = $clog2(C_START_CYC + 1);
  localparam logic [C_LOW_W-1:0] C_LOW_SAT = C_LOW_W'(C_START_CYC);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOST_LOW  = 3'd1,
    S_WAIT      = 3'd2,
    S_RESP_LOW  = 3'd3,
    S_RESP_HIGH = 3'd4,
    S_BIT_LOW   = 3'd5,
    S_BIT_HIGH  = 3'd6,
    S_END_LOW   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [C_PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [C_LOW_W-1:0]  low_cnt_q, low_cnt_d;
  logic [39:0]         shreg_q, shreg_d;
  logic [5:0]          bit_idx_q, bit_idx_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                line_s;
  logic                ph_done;
  logic [7:0]          sum8;
  logic [7:0]          chk;

  assign line_s  = sync2_q;
  assign ph_done = (ph_cnt_q == '0);
  assign sum8    = bus.hum_int + bus.hum_dec + bus.temp_int + bus.temp_dec;
  assign chk     = sum8 ^ bus.chk_xor;

  // Two-stage synchronizer for the asynchronous data line (idle level is high)
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.dht_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: phase timing, start-pulse qualification and frame shifting
  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    low_cnt_d = low_cnt_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable && !line_s) begin
          state_d   = S_HOST_LOW;
          low_cnt_d = '0;
        end
      end
      S_HOST_LOW: begin
        if (line_s) begin
          if (low_cnt_q == C_LOW_SAT) begin
            state_d  = S_WAIT;
            ph_cnt_d = C_PH_W'(C_WAIT_CYC - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else if (low_cnt_q != C_LOW_SAT) begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A new low during the wait restarts start-pulse qualification
        if (!line_s) begin
          state_d   = S_HOST_LOW;
          low_cnt_d = '0;
        end else if (!ph_done) begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end else begin
          state_d  = S_RESP_LOW;
          ph_cnt_d = C_PH_W'(C_RLOW_CYC - 1);
          shreg_d  = {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec, chk};
        end
      end
      S_RESP_LOW: begin
        if (!ph_done) begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end else begin
          state_d  = S_RESP_HIGH;
          ph_cnt_d = C_PH_W'(C_RHIGH_CYC - 1);
        end
      end
      S_RESP_HIGH: begin
        if (!ph_done) begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end else begin
          state_d   = S_BIT_LOW;
          ph_cnt_d  = C_PH_W'(C_BLOW_CYC - 1);
          bit_idx_d = '0;
        end
      end
      S_BIT_LOW: begin
        if (!ph_done) begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end else begin
          state_d  = S_BIT_HIGH;
          ph_cnt_d = shreg_q[39] ? C_PH_W'(C_ONE_CYC - 1) : C_PH_W'(C_ZERO_CYC - 1);
        end
      end
      S_BIT_HIGH: begin
        if (!ph_done) begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end else begin
          shreg_d = {shreg_q[38:0], 1'b0};
          if (bit_idx_q == 6'd39) begin
            state_d  = S_END_LOW;
            ph_cnt_d = C_PH_W'(C_END_CYC - 1);
          end else begin
            state_d   = S_BIT_LOW;
            ph_cnt_d  = C_PH_W'(C_BLOW_CYC - 1);
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_END_LOW: begin
        if (!ph_done) begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state so they are registered in step with it
    oe_d   = (state_d == S_RESP_LOW) || (state_d == S_BIT_LOW) || (state_d == S_END_LOW);
    busy_d = (state_d != S_IDLE) && (state_d != S_HOST_LOW);
  end

  // State and registered outputs; reset releases the line immediately
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ph_cnt_q  <= '0;
      low_cnt_q <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_cnt_q  <= ph_cnt_d;
      low_cnt_q <= low_cnt_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.dht_oe     = oe_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dht11_sensor_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_dht11_sensor_emulator                                          |
// | Brief  : Self-checking bench: host start pulses, pulse-width decoding of   |
// |          the emulator reply against a frame/timing reference model.        |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_dht11_sensor_emulator;

  localparam int CYC          = 2;
  localparam int START_US     = 100;
  localparam int WAIT_US      = 30;
  localparam int RESP_LOW_US  = 80;
  localparam int RESP_HIGH_US = 80;
  localparam int BIT_LOW_US   = 50;
  localparam int ZERO_HIGH_US = 26;
  localparam int ONE_HIGH_US  = 70;
  localparam int END_LOW_US   = 50;

  typedef struct {
    string      tag;
    logic [7:0] h, hd, t, td, x;
    int         low_us;
    bit         en;
    bit         resp;
    logic [7:0] chk;
  } vec_t;

  logic clk_50Mhz = 1'b0;
  logic rst_n     = 1'b0;
  always #5 clk_50Mhz = ~clk_50Mhz;

  dht11_sensor_emulator_if bus();

  dht11_sensor_emulator #(
    .CYC_PER_US   (CYC),
    .START_MIN_US (START_US)
  ) dut (
    .clk_50Mhz (clk_50Mhz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int oe_cyc = 0;
  int busy_cyc = 0;
  int fd_cnt = 0;

  // Background activity counters sampled mid-cycle
  always @(negedge clk_50Mhz) begin
    if (bus.dht_oe)     oe_cyc   <= oe_cyc + 1;
    if (bus.busy)       busy_cyc <= busy_cyc + 1;
    if (bus.frame_done) fd_cnt   <= fd_cnt + 1;
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50Mhz);
    #1;
  endtask

  // Reference: checksum is the byte sum modulo 256, then XOR-masked
  function automatic logic [7:0] ref_chk(input logic [7:0] h, hd, t, td, x);
    int s;
    s = (int'(h) + int'(hd) + int'(t) + int'(td)) % 256;
    return 8'(s) ^ x;
  endfunction

  task automatic apply(input vec_t v);
    bus.hum_int  = v.h;
    bus.hum_dec  = v.hd;
    bus.temp_int = v.t;
    bus.temp_dec = v.td;
    bus.chk_xor  = v.x;
    bus.enable   = v.en;
  endtask

  task automatic host_start(input int low_us);
    bus.dht_in = 1'b0;
    repeat (low_us * CYC) tick();
    bus.dht_in = 1'b1;
  endtask

  // Length of the run of dht_oe==lvl that the current sample begins; -1 on timeout
  task automatic measure(input logic lvl, output int n);
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bus.dht_oe !== lvl) return;
      n++;
    end
    n = -1;
  endtask

  task automatic wait_response(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      lat++;
      if (bus.dht_oe === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    lat = -1;
  endtask

  // Decodes the reply from the first RESP_LOW sample; stops at bit stop_bit's low if >= 0
  task automatic capture_rest(input logic [39:0] exp, input int stop_bit, input string tag, output bit ok);
    int n;
    logic [39:0] got;
    ok  = 1'b0;
    got = '0;
    measure(1'b1, n);
    check($sformatf("%s resp_low", tag), n, RESP_LOW_US * CYC);
    if (n < 0) return;
    measure(1'b0, n);
    check($sformatf("%s resp_high", tag), n, RESP_HIGH_US * CYC);
    if (n < 0) return;
    for (int b = 0; b < 40; b++) begin
      if (b == stop_bit) begin
        ok = 1'b1;
        return;
      end
      measure(1'b1, n);
      check($sformatf("%s bit%0d_low", tag, b), n, BIT_LOW_US * CYC);
      if (n < 0) return;
      measure(1'b0, n);
      check($sformatf("%s bit%0d_high", tag, b), n, exp[39-b] ? ONE_HIGH_US * CYC : ZERO_HIGH_US * CYC);
      if (n < 0) return;
      got[39-b] = (n > (ZERO_HIGH_US + ONE_HIGH_US) * CYC / 2);
    end
    measure(1'b1, n);
    check($sformatf("%s end_low", tag), n, END_LOW_US * CYC);
    if (n < 0) return;
    check($sformatf("%s frame_done", tag), bus.frame_done, 1);
    check($sformatf("%s busy_end", tag), bus.busy, 0);
    check($sformatf("%s frame", tag), got, exp);
    tick();
    check($sformatf("%s frame_done_pulse", tag), bus.frame_done, 0);
    ok = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, fd0, oe0, b0;
    bit ok;
    apply(v);
    fd0 = fd_cnt;
    oe0 = oe_cyc;
    b0  = busy_cyc;
    host_start(v.low_us);
    if (!v.resp) begin
      repeat (2 * WAIT_US * CYC + 20) tick();
      check($sformatf("%s no_oe", v.tag), oe_cyc - oe0, 0);
      check($sformatf("%s no_busy", v.tag), busy_cyc - b0, 0);
      check($sformatf("%s no_done", v.tag), fd_cnt - fd0, 0);
      return;
    end
    wait_response(lat, ok);
    // two synchronizer stages, one cycle for the FSM to act, then the wait phase
    check($sformatf("%s latency", v.tag), lat, 3 + WAIT_US * CYC);
    if (!ok) return;
    check($sformatf("%s busy", v.tag), bus.busy, 1);
    capture_rest({v.h, v.hd, v.t, v.td, v.chk}, -1, v.tag, ok);
    repeat (2) tick();
    check($sformatf("%s done_count", v.tag), fd_cnt - fd0, 1);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int lat;
    bit ok;

    bus.enable   = 1'b1;
    bus.dht_in   = 1'b1;
    bus.hum_int  = '0;
    bus.hum_dec  = '0;
    bus.temp_int = '0;
    bus.temp_dec = '0;
    bus.chk_xor  = '0;

    vecs.push_back('{"t1",  8'h37, 8'h00, 8'h19, 8'h00, 8'h00, 120, 1'b1, 1'b1, 8'h50});
    vecs.push_back('{"t2",  8'h37, 8'h00, 8'h19, 8'h00, 8'h00,  60, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{"t3",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 120, 1'b1, 1'b1, 8'hFD});
    vecs.push_back('{"t4a", 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 120, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{"t4b", 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 120, 1'b1, 1'b1, 8'h14});
    for (int i = 0; i < 3; i++) begin
      v.tag    = $sformatf("rnd%0d", i);
      v.h      = 8'($urandom);
      v.hd     = 8'($urandom);
      v.t      = 8'($urandom);
      v.td     = 8'($urandom);
      v.x      = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      v.en     = (i != 1) ? 1'b1 : 1'($urandom_range(0, 1));
      v.low_us = (i != 1) ? int'($urandom_range(110, 130)) : int'($urandom_range(10, 95));
      v.resp   = v.en && (v.low_us > START_US);
      v.chk    = ref_chk(v.h, v.hd, v.t, v.td, v.x);
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk_50Mhz);
    #1;
    check("reset dht_oe", bus.dht_oe, 0);
    check("reset busy", bus.busy, 0);
    check("reset frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during bit 12's low slot, then a complete fresh frame
    v = '{"t5", 8'hA5, 8'h3C, 8'h0F, 8'hC3, 8'h00, 120, 1'b1, 1'b1, 8'h00};
    v.chk = ref_chk(v.h, v.hd, v.t, v.td, v.x);
    apply(v);
    host_start(v.low_us);
    wait_response(lat, ok);
    check("t5 latency", lat, 3 + WAIT_US * CYC);
    if (ok) capture_rest({v.h, v.hd, v.t, v.td, v.chk}, 12, "t5", ok);
    check("t5 in_bit12_low", bus.dht_oe, 1);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5 rst dht_oe", bus.dht_oe, 0);
    check("t5 rst busy", bus.busy, 0);
    check("t5 rst frame_done", bus.frame_done, 0);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (4) tick();
    check("t5 idle after rst", bus.busy, 0);
    v.tag = "t5fresh";
    run_vec(v);

    // Payload changes after the frame is latched must not leak into it
    v = '{"t6", 8'h10, 8'h22, 8'h18, 8'h05, 8'h00, 120, 1'b1, 1'b1, 8'h00};
    v.chk = ref_chk(v.h, v.hd, v.t, v.td, v.x);
    apply(v);
    host_start(v.low_us);
    wait_response(lat, ok);
    check("t6 latency", lat, 3 + WAIT_US * CYC);
    bus.hum_int = 8'h20;
    if (ok) capture_rest({v.h, v.hd, v.t, v.td, v.chk}, -1, "t6", ok);
    repeat (2) tick();
    v.tag = "t6next";
    v.h   = 8'h20;
    v.chk = ref_chk(v.h, v.hd, v.t, v.td, v.x);
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
